fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch stage for the 5-stage pipeline. It holds the fetch PC and issues one instruction-memory read at a time over a req/rvalid handshake. Returned words are buffered in a DEPTH-entry queue that decouples memory latency from decode backpressure. Branch and interrupt redirects flush the queue and discard any in-flight response.

---
 rtl/fetch_queue_unit_if.sv | 25 ++
 rtl/fetch_queue_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Fetch stage bus bundle: instruction-memory request/response and the decode-side
// queue head handshake. The fetch unit is the master; memory/decode sit on the slave side.
interface fetch_queue_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc,
        input  imem_rvalid, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc,
        output imem_rvalid, imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: single outstanding imem read feeding a DEPTH-entry queue,
// with branch/interrupt redirects. Optional perf counters under FETCH_PERF_CNT_EN.
//
//   state | meaning
//   IDLE  | no request outstanding; issue when queue has room and no redirect
//   WAIT  | request outstanding; response is pushed with its fetch PC
//   DROP  | request outstanding after a redirect; response will be discarded
module fetch_queue_unit #(
    parameter int              ADDR_W    = 32,
    parameter int              INST_W    = 16,
    parameter int              BR_W      = 16,
    parameter int              DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(50),
    parameter logic [ADDR_W-1:0] INT_VEC   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_queue_unit_if.master     bus,
    input  logic                   branch_i,
    input  logic [BR_W-1:0]        branch_addr_i,
    input  logic                   int_req_i,
    output logic [ADDR_W-1:0]      epc_o,
    output logic [$clog2(DEPTH):0] q_count_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetched_o,
    output logic [31:0]            perf_stall_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] epc_q;
    logic              req_q;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_q, rd_q;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic              redirect, push, pop, out_valid;
    logic [ADDR_W-1:0] br_tgt;

    assign redirect  = int_req_i | branch_i;
    assign out_valid = (count_q != '0);
    assign push      = (state_q == WAIT) && bus.imem_rvalid && !redirect;
    assign pop       = out_valid && bus.out_ready && !redirect;
    assign br_tgt    = ADDR_W'($signed(branch_addr_i));

    always_comb begin
        fpc_d = fpc_q;
        if (int_req_i)     fpc_d = INT_VEC;
        else if (branch_i) fpc_d = br_tgt;
        else if (push)     fpc_d = fpc_q + 1'b1;

        count_d = count_q;
        if (redirect)           count_d = '0;
        else if (push && !pop)  count_d = count_q + 1'b1;
        else if (pop && !push)  count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fpc_q   <= RESET_VEC;
            addr_q  <= '0;
            epc_q   <= '0;
            req_q   <= 1'b0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            fpc_q   <= fpc_d;
            count_q <= count_d;
            if (int_req_i)
                epc_q <= out_valid ? pc_mem_q[rd_q] : fpc_q;

            if (redirect) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop)  rd_q <= rd_q + 1'b1;
            end

            // A redirect never aborts the bus transaction; it only poisons the response.
            case (state_q)
                IDLE: begin
                    if (!redirect && (count_q < CW'(DEPTH))) begin
                        req_q   <= 1'b1;
                        addr_q  <= fpc_q;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (redirect) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_q]   <= fpc_q;
            inst_mem_q[wr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = out_valid;
    assign bus.out_inst  = inst_mem_q[rd_q];
    assign bus.out_pc    = pc_mem_q[rd_q];
    assign epc_o         = epc_q;
    assign q_count_o     = count_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (pop && !(&perf_fetched_q))
                perf_fetched_q <= perf_fetched_q + 1'b1;
            if (out_valid && !bus.out_ready && !(&perf_stall_q))
                perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_stall_o   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: latency-programmable memory responder, a queue-level
// reference model of the fetch stream, directed scenarios and a randomized run.
module tb_fetch_queue_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        branch = 1'b0;
    logic [15:0] branch_addr = '0;
    logic        int_req = 1'b0;
    logic [31:0] epc;
    logic [2:0]  q_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int n_vec = 0;
    int n_fail = 0;
    int lat = 1;
    bit mem_en = 1'b1;
    bit late_pulse = 1'b0;

    // reference model state
    ent_t        m_q[$];
    logic [31:0] m_fpc = 32'd50;
    logic [31:0] m_epc = '0;
    bit          m_dead = 1'b0;
    bit          m_req_prev = 1'b0;
    bit          m_resp_last = 1'b0;
    logic [31:0] m_addr_prev = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] m_pops = '0;
    logic [31:0] m_stalls = '0;
`endif

    always #5 clk = ~clk;

    fetch_queue_unit_if #(.ADDR_W(32), .INST_W(16)) bus ();

    fetch_queue_unit #(.ADDR_W(32), .INST_W(16), .BR_W(16), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .branch_i(branch),
        .branch_addr_i(branch_addr),
        .int_req_i(int_req),
        .epc_o(epc),
        .q_count_o(q_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o(perf_fetched),
        .perf_stall_o(perf_stall)
`endif
    );

    // Memory: rvalid is a one-cycle pulse in the lat-th cycle the request is seen.
    initial begin
        int cnt;
        cnt = 0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.imem_rvalid) begin
                bus.imem_rvalid = 1'b0;
                cnt = 0;
            end else if (late_pulse) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = 16'($urandom);
                cnt = 0;
            end else if (mem_en && bus.imem_req) begin
                cnt++;
                if (cnt >= lat) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = 16'($urandom);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Model: the fetch stream as an ordered queue of (pc, word) with flush on redirect.
    always @(posedge clk) begin
        int  sz;
        bit  resp, redir;
        sz          = m_q.size();
        resp        = bus.imem_rvalid && bus.imem_req;
        redir       = int_req || branch;
        m_req_prev  = bus.imem_req;
        m_addr_prev = bus.imem_addr;
        if (reset) begin
            m_q.delete();
            m_fpc       = 32'd50;
            m_epc       = '0;
            m_dead      = 1'b0;
            m_resp_last = 1'b0;
`ifdef FETCH_PERF_CNT_EN
            m_pops   = '0;
            m_stalls = '0;
`endif
        end else begin
            if (int_req) m_epc = (sz > 0) ? m_q[0].pc : m_fpc;
`ifdef FETCH_PERF_CNT_EN
            if (sz > 0 && !bus.out_ready && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            if (sz > 0 && bus.out_ready && !redir && m_pops != 32'hFFFF_FFFF) m_pops++;
`endif
            if (sz > 0 && bus.out_ready && !redir) void'(m_q.pop_front());
            if (resp && !m_dead && !redir) begin
                m_q.push_back('{pc: m_fpc, inst: bus.imem_rdata});
                m_fpc = m_fpc + 1;
            end
            m_resp_last = resp;
            if (resp) m_dead = 1'b0;
            if (int_req)     m_fpc = 32'd0;
            else if (branch) m_fpc = {{16{branch_addr[15]}}, branch_addr};
            if (redir) begin
                m_q.delete();
                if (bus.imem_req && !resp) m_dead = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; branch = 1'b0; int_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.out_ready = 1'b1;
        tick(); tick();
        n_vec++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_q_count: got %0d want 0", q_count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
        n_vec++; if (epc !== 32'd0) begin n_fail++; $display("FAIL reset_epc: got %0h want 0", epc); end
        reset = 1'b0;
        tick();
        n_vec++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        n_vec++; if (bus.imem_addr !== 32'd50) begin n_fail++; $display("FAIL first_addr: got %0d want 50", bus.imem_addr); end
    endtask

    task automatic test_stream();
        int got;
        lat = 1; bus.out_ready = 1'b1;
        do_reset();
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (m_resp_last) begin
                n_vec++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_req_gap: got %b want 0", bus.imem_req); end
            end
            if (bus.out_valid) begin
                n_vec++; if (bus.out_pc !== 32'd50 + 32'(got)) begin n_fail++; $display("FAIL stream_pc: got %0d want %0d", bus.out_pc, 50 + got); end
                n_vec++;
                if (m_q.size() == 0) begin n_fail++; $display("FAIL stream_inst: got %0h want none", bus.out_inst); end
                else if (bus.out_inst !== m_q[0].inst) begin n_fail++; $display("FAIL stream_inst: got %0h want %0h", bus.out_inst, m_q[0].inst); end
                got++;
            end
            tick();
        end
        n_vec++; if (got != 6) begin n_fail++; $display("FAIL stream_count: got %0d want 6", got); end
    endtask

    task automatic test_backpressure();
        int  got;
        bit  seen;
        lat = 1; bus.out_ready = 1'b0;
        do_reset();
        repeat (20) tick();
        n_vec++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL bp_full_count: got %0d want 4", q_count); end
        n_vec++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b want 0", bus.imem_req); end
        bus.out_ready = 1'b1;
        got = 0; seen = 1'b0;
        for (int c = 0; c < 30 && (got < 4 || !seen); c++) begin
            if (bus.out_valid && got < 4) begin
                n_vec++; if (bus.out_pc !== 32'd50 + 32'(got)) begin n_fail++; $display("FAIL bp_pop_pc: got %0d want %0d", bus.out_pc, 50 + got); end
                got++;
            end
            if (bus.imem_req && !m_req_prev && !seen) begin
                seen = 1'b1;
                n_vec++; if (bus.imem_addr !== 32'd54) begin n_fail++; $display("FAIL bp_resume_addr: got %0d want 54", bus.imem_addr); end
            end
            tick();
        end
        n_vec++; if (got != 4 || !seen) begin n_fail++; $display("FAIL bp_timeout: got pops %0d resume %0d want 4 1", got, seen); end
    endtask

    task automatic test_branch_drop();
        logic [31:0] old;
        int c;
        lat = 3; bus.out_ready = 1'b1;
        do_reset();
        for (c = 0; c < 10 && !bus.imem_req; c++) tick();
        old = bus.imem_addr;
        branch = 1'b1; branch_addr = 16'hFFF0;
        tick();
        branch = 1'b0;
        n_vec++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL br_flush_count: got %0d want 0", q_count); end
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== old) begin n_fail++; $display("FAIL br_drop_hold: got req %b addr %0h want 1 %0h", bus.imem_req, bus.imem_addr, old); end
        for (c = 0; c < 10 && bus.imem_req; c++) begin
            n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL br_drop_valid: got %b want 0", bus.out_valid); end
            tick();
        end
        for (c = 0; c < 10 && !bus.imem_req; c++) tick();
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL br_new_addr: got req %b addr %0h want 1 fffffff0", bus.imem_req, bus.imem_addr); end
        for (c = 0; c < 10 && !bus.out_valid; c++) tick();
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL br_first_pc: got valid %b pc %0h want 1 fffffff0", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_int();
        int c;
        lat = 1; bus.out_ready = 1'b1;
        do_reset();
        for (c = 0; c < 40 && !(bus.out_valid && bus.out_pc == 32'd52); c++) tick();
        n_vec++; if (!(bus.out_valid && bus.out_pc == 32'd52)) begin n_fail++; $display("FAIL int_setup: got pc %0d want 52", bus.out_pc); end
        int_req = 1'b1; branch = 1'b1; branch_addr = 16'($urandom_range(1, 16'h7FFF)); bus.out_ready = 1'b0;
        tick();
        int_req = 1'b0; branch = 1'b0; bus.out_ready = 1'b1;
        n_vec++; if (epc !== 32'd52) begin n_fail++; $display("FAIL int_epc: got %0d want 52", epc); end
        n_vec++; if (q_count !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL int_flush: got count %0d valid %b want 0 0", q_count, bus.out_valid); end
        for (c = 0; c < 15 && !(bus.imem_req && !m_req_prev); c++) tick();
        n_vec++; if (bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL int_vec_addr: got %0h want 0", bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        int c;
        lat = 3; bus.out_ready = 1'b1;
        do_reset();
        for (c = 0; c < 10 && !bus.imem_req; c++) tick();
        mem_en = 1'b0; reset = 1'b1;
        #1 late_pulse = 1'b1;
        tick();
        reset = 1'b0;
        #1 late_pulse = 1'b0;
        tick();
        mem_en = 1'b1;
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd50) begin n_fail++; $display("FAIL rst_mid_restart: got req %b addr %0d want 1 50", bus.imem_req, bus.imem_addr); end
        n_vec++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", q_count); end
        for (c = 0; c < 10 && !bus.out_valid; c++) tick();
        n_vec++; if (bus.out_pc !== 32'd50 || m_q.size() == 0 || bus.out_inst !== m_q[0].inst) begin n_fail++; $display("FAIL rst_mid_first: got pc %0d want 50 with model word", bus.out_pc); end
    endtask

    task automatic test_wrap();
        int rises, pops;
        lat = 1; bus.out_ready = 1'b1;
        do_reset();
        branch = 1'b1; branch_addr = 16'hFFFF;
        tick();
        branch = 1'b0;
        rises = 0; pops = 0;
        for (int c = 0; c < 30 && (rises < 2 || pops < 2); c++) begin
            if (bus.imem_req && !m_req_prev && rises < 2) begin
                n_vec++; if (bus.imem_addr !== (rises == 0 ? 32'hFFFF_FFFF : 32'd0)) begin n_fail++; $display("FAIL wrap_addr%0d: got %0h", rises, bus.imem_addr); end
                rises++;
            end
            if (bus.out_valid && pops < 2) begin
                n_vec++; if (bus.out_pc !== (pops == 0 ? 32'hFFFF_FFFF : 32'd0)) begin n_fail++; $display("FAIL wrap_pc%0d: got %0h", pops, bus.out_pc); end
                pops++;
            end
            tick();
        end
        n_vec++; if (rises != 2 || pops != 2) begin n_fail++; $display("FAIL wrap_timeout: got %0d %0d want 2 2", rises, pops); end
    endtask

    task automatic test_random();
        int bias;
        bias = 3;
        bus.out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            n_vec++; if (int'(q_count) !== m_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", q_count, m_q.size()); end
            n_vec++; if (bus.out_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid: got %b want %b", bus.out_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                n_vec++; if ({bus.out_pc, bus.out_inst} !== m_q[0]) begin n_fail++; $display("FAIL rnd_head: got %0h/%0h want %0h/%0h", bus.out_pc, bus.out_inst, m_q[0].pc, m_q[0].inst); end
            end
            if (bus.imem_req && !m_req_prev) begin
                n_vec++; if (bus.imem_addr !== m_fpc) begin n_fail++; $display("FAIL rnd_issue_addr: got %0h want %0h", bus.imem_addr, m_fpc); end
            end
            if (bus.imem_req && m_req_prev) begin
                n_vec++; if (bus.imem_addr !== m_addr_prev) begin n_fail++; $display("FAIL rnd_addr_stable: got %0h want %0h", bus.imem_addr, m_addr_prev); end
            end
            n_vec++; if (epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc: got %0h want %0h", epc, m_epc); end
            if (c % 64 == 0) bias = $urandom_range(0, 4);
            bus.out_ready = ($urandom_range(0, 3) < bias);
            branch      = ($urandom_range(0, 39) == 0);
            int_req     = ($urandom_range(0, 59) == 0);
            branch_addr = 16'($urandom);
            lat         = $urandom_range(1, 3);
            tick();
        end
        branch = 1'b0; int_req = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        n_vec++; if (perf_fetched !== m_pops) begin n_fail++; $display("FAIL perf_fetched: got %0d want %0d", perf_fetched, m_pops); end
        n_vec++; if (perf_stall !== m_stalls) begin n_fail++; $display("FAIL perf_stall: got %0d want %0d", perf_stall, m_stalls); end
`endif
    endtask

    initial begin
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_drop();
        test_int();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
